bram_readback_streamer: RTL

- Read-side controller for the single-clock block RAM (registered read, 1-cycle latency, WID_MEM x DEPTH_MEM).
- On a start pulse, sweeps a contiguous address range and streams each word, tagged with its address, over a valid/ready interface.
- Accumulates a 32-bit additive checksum so reinitialised contents can be verified against the init file without a full dump.
- Sits between the memory instance and the readback/compare logic; it never drives the memory write port.

---
 rtl/bram_readback_streamer_if.sv | 36 +++
 rtl/bram_readback_streamer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bram_readback_streamer_if.sv
// ---------------------------------------------------------------------------
// bram_readback_streamer_if
//   Valid/ready stream carrying memory words tagged with their address.
//
//   m_valid  beat valid (master -> slave)
//   m_ready  beat accepted when m_valid && m_ready (slave -> master)
//   m_data   memory word
//   m_addr   address the word was read from
//   m_last   final beat of a sweep
// ---------------------------------------------------------------------------
interface bram_readback_streamer_if #(
    parameter int WID_MEM = 18,
    parameter int ADDR_W  = 12
);
    logic               m_valid;
    logic               m_ready;
    logic [WID_MEM-1:0] m_data;
    logic [ADDR_W-1:0]  m_addr;
    logic               m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_addr,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_addr,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/bram_readback_streamer.sv
// ---------------------------------------------------------------------------
// bram_readback_streamer
//   Read-side controller for a single-clock block RAM with a registered
//   (1-cycle latency) read port. On start it sweeps a contiguous, wrapping
//   address range, streams every word with its address over a valid/ready
//   interface and accumulates a 32-bit additive checksum of accepted beats.
//
//   clk         rising-edge clock
//   reset       asynchronous, active-high
//   start       begin a sweep (sampled only when idle)
//   start_addr  first address, captured on start
//   num_words   word count, captured on start, clamped to DEPTH_MEM
//   busy        start acceptance .. final beat handshake
//   done        one-cycle completion pulse
//   checksum    sum mod 2**32 of accepted beat data, held until next start
//   mem_raddr   memory read address
//   mem_dout    memory read data (valid the cycle after mem_raddr)
//   m           output stream (master side)
// ---------------------------------------------------------------------------
module bram_readback_streamer #(
    parameter int WID_MEM   = 18,
    parameter int DEPTH_MEM = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     num_words,
    output logic                busy,
    output logic                done,
    output logic [31:0]         checksum,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic [WID_MEM-1:0]  mem_dout,
    bram_readback_streamer_if.master m
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH_MEM);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH_MEM - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
        return (n > DEPTH_L) ? DEPTH_L : n;
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_A) ? '0 : a + ADDR_W'(1);
    endfunction

    state_t              state;
    logic [ADDR_W:0]     count;
    logic [ADDR_W:0]     issued;
    logic [ADDR_W-1:0]   issue_addr;
    logic [ADDR_W-1:0]   raddr_hold;

    // read in flight: issued last cycle, data on mem_dout this cycle
    logic                vld_p1;
    logic                last_p1;
    logic [ADDR_W-1:0]   addr_p1;

    // second FIFO entry behind the output register
    logic                vld_sk;
    logic                last_sk;
    logic [ADDR_W-1:0]   addr_sk;
    logic [WID_MEM-1:0]  data_sk;

    logic [ADDR_W:0]     cnt_clamped;
    logic [1:0]          occ;
    logic [2:0]          pending;
    logic                pop;
    logic                issue;
    logic                issue_last;
    logic                load_out;
    logic                sk_push;

    always_comb begin
        cnt_clamped = clamp_count(num_words);
        pop         = m.m_valid & m.m_ready;
        occ         = {1'b0, m.m_valid} + {1'b0, vld_sk};
        // Counting this cycle's pop lets a full pipeline sustain one beat
        // per cycle; the cost is a combinational path m_ready -> mem_raddr.
        pending     = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop};
        issue       = (state == S_READ) && (issued != count) && (pending < 3'd2);
        issue_last  = (issued == count - (ADDR_W+1)'(1));
        mem_raddr   = issue ? issue_addr : raddr_hold;
        load_out    = !m.m_valid || pop;
        // an arriving word lands in the skid entry when the output register
        // stays occupied, or when the skid entry shifts forward this cycle
        sk_push     = vld_p1 && m.m_valid && (!pop || vld_sk);
    end

    // issue stage / control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
            count      <= '0;
            issued     <= '0;
            issue_addr <= '0;
            raddr_hold <= '0;
            vld_p1     <= 1'b0;
            vld_sk     <= 1'b0;
            m.m_valid  <= 1'b0;
            m.m_data   <= '0;
            m.m_addr   <= '0;
            m.m_last   <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p1 <= issue;

            if (issue) begin
                issued     <= issued + (ADDR_W+1)'(1);
                issue_addr <= wrap_inc(issue_addr);
                raddr_hold <= issue_addr;
            end

            if (pop) begin
                checksum <= checksum + 32'(m.m_data);
            end

            // output stage: refill from the skid entry first to keep order
            if (load_out) begin
                if (vld_sk) begin
                    m.m_valid <= 1'b1;
                    m.m_data  <= data_sk;
                    m.m_addr  <= addr_sk;
                    m.m_last  <= last_sk;
                end else if (vld_p1) begin
                    m.m_valid <= 1'b1;
                    m.m_data  <= mem_dout;
                    m.m_addr  <= addr_p1;
                    m.m_last  <= last_p1;
                end else begin
                    m.m_valid <= 1'b0;
                end
            end
            vld_sk <= (vld_sk && !load_out) || sk_push;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        issue_addr <= start_addr;
                        count      <= cnt_clamped;
                        issued     <= '0;
                        checksum   <= '0;
                        if (cnt_clamped == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (issue && issue_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && m.m_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // data-only registers travelling with vld_p1 / vld_sk
    always_ff @(posedge clk) begin
        if (issue) begin
            addr_p1 <= issue_addr;
            last_p1 <= issue_last;
        end
        if (sk_push) begin
            data_sk <= mem_dout;
            addr_sk <= addr_p1;
            last_sk <= last_p1;
        end
    end

endmodule
